// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg: FSM states, register map, command codes and status bits shared by the RAM DMA controller.
package ram_dma_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_START,
        S_RD_BEAT,
        S_WR_PREFETCH,
        S_WR_BEAT,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] REG_BUS_ADDR   = 3'd0;
    localparam logic [2:0] REG_MEM_ADDR   = 3'd1;
    localparam logic [2:0] REG_BLOCK_SIZE = 3'd2;
    localparam logic [2:0] REG_BURST_SIZE = 3'd3;
    localparam logic [2:0] REG_CONTROL    = 3'd4;
    localparam logic [2:0] REG_STATUS     = 3'd5;

    localparam logic [31:0] CMD_BUS2MEM = 32'd1;
    localparam logic [31:0] CMD_MEM2BUS = 32'd2;

    localparam int ST_BUSY  = 0;
    localparam int ST_ERROR = 1;
    localparam int ST_DONE  = 2;

    // Beats in the next burst: the remaining word count capped at burstSize+1.
    function automatic logic [15:0] burst_beats(input logic [15:0] remaining, input logic [7:0] burst_size);
        logic [15:0] cap;
        cap = {8'd0, burst_size} + 16'd1;
        return (remaining < cap) ? remaining : cap;
    endfunction

endpackage

// File: rtl/ram_dma_cfg_regs.sv
// ram_dma_cfg_regs: processor-side register window with busy write-lock and registered read mux.
module ram_dma_cfg_regs
    import ram_dma_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          valid,
    input  logic          write_enable,
    input  logic [2:0]    reg_sel,
    input  logic [31:0]   data_in,
    output logic [31:0]   data_out,
    output logic          ack,
    input  logic          lock,
    input  logic          busy,
    input  logic          error,
    input  logic          done,
    output logic [31:0]   bus_start_addr,
    output logic [AW-1:0] mem_start_addr,
    output logic [15:0]   block_size,
    output logic [7:0]    burst_size,
    output logic          start_bus2mem,
    output logic          start_mem2bus,
    output logic          status_clear
);

    logic        wr;
    logic        cfg_wr;
    logic [31:0] rd_mux;

    assign wr            = valid && write_enable;
    assign cfg_wr        = wr && !lock;
    assign start_bus2mem = cfg_wr && reg_sel == REG_CONTROL && data_in == CMD_BUS2MEM;
    assign start_mem2bus = cfg_wr && reg_sel == REG_CONTROL && data_in == CMD_MEM2BUS;
    assign status_clear  = wr && reg_sel == REG_STATUS;

    // Read mux; control is write-only and unused indices read as zero.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_BUS_ADDR:   rd_mux = bus_start_addr;
            REG_MEM_ADDR:   rd_mux = 32'(mem_start_addr);
            REG_BLOCK_SIZE: rd_mux = 32'(block_size);
            REG_BURST_SIZE: rd_mux = 32'(burst_size);
            REG_STATUS:     rd_mux = {29'd0, done, error, busy};
            default:        rd_mux = '0;
        endcase
    end

    // Register file updates plus the one-cycle registered acknowledge and read data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_out       <= '0;
            ack            <= 1'b0;
            bus_start_addr <= '0;
            mem_start_addr <= '0;
            block_size     <= '0;
            burst_size     <= '0;
        end else begin
            ack      <= valid;
            data_out <= (valid && !write_enable) ? rd_mux : '0;
            if (cfg_wr && reg_sel == REG_BUS_ADDR)   bus_start_addr <= {data_in[31:2], 2'b00};
            if (cfg_wr && reg_sel == REG_MEM_ADDR)   mem_start_addr <= data_in[AW-1:0];
            if (cfg_wr && reg_sel == REG_BLOCK_SIZE) block_size     <= data_in[15:0];
            if (cfg_wr && reg_sel == REG_BURST_SIZE) burst_size     <= data_in[7:0];
        end
    end

endmodule

// File: rtl/ram_dma_controller.sv
// ram_dma_controller: SSRAM port-B DMA sequencer between scratch memory and system bus; RAM_DMA_IRQ_EN adds an irq output.
module ram_dma_controller
    import ram_dma_pkg::*;
#(
    parameter int nrOfEntries = 512,
    parameter int bitwidth    = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cfgValid,
    input  logic                           cfgWriteEnable,
    input  logic [2:0]                     cfgRegSel,
    input  logic [31:0]                    cfgDataIn,
    output logic [31:0]                    cfgDataOut,
    output logic                           cfgDone,
    output logic                           busRequest,
    input  logic                           busGrant,
    output logic                           busStart,
    output logic [31:0]                    busAddress,
    output logic [7:0]                     busBurstLen,
    output logic                           busReadNotWrite,
    input  logic [bitwidth-1:0]            busDataIn,
    input  logic                           busDataValidIn,
    output logic [bitwidth-1:0]            busDataOut,
    output logic                           busDataValidOut,
    input  logic                           busBusyIn,
    input  logic                           busErrorIn,
    output logic                           busEndOut,
    output logic [$clog2(nrOfEntries)-1:0] memAddress,
    output logic                           memWriteEnable,
    output logic [bitwidth-1:0]            memDataOut,
    input  logic [bitwidth-1:0]            memDataIn
`ifdef RAM_DMA_IRQ_EN
    ,
    output logic                           irq
`endif
);

    localparam int AW = $clog2(nrOfEntries);

    state_t              state, state_next;
    logic                busy, error, done;
    logic                dir;
    logic                fresh;
    logic [15:0]         rem;
    logic [31:0]         bus_addr;
    logic [AW-1:0]       mem_addr;
    logic [7:0]          burst_len, beat_cnt;
    logic [bitwidth-1:0] wdata_hold;
    logic [31:0]         bus_start_addr;
    logic [AW-1:0]       mem_start_addr;
    logic [15:0]         block_size;
    logic [7:0]          burst_size;
    logic                start_bus2mem, start_mem2bus, status_clear, start_any;
    logic [15:0]         beats_now, beats_done, rem_after;
    logic                last;

    assign start_any       = start_bus2mem || start_mem2bus;
    assign beats_now       = burst_beats(rem, burst_size);
    assign beats_done      = {8'd0, burst_len} + 16'd1;
    assign rem_after       = rem - beats_done;
    assign last            = beat_cnt == 8'd0;
    assign busAddress      = bus_addr;
    assign busBurstLen     = burst_len;
    assign busReadNotWrite = dir;
    assign memAddress      = mem_addr;

`ifdef RAM_DMA_IRQ_EN
    assign irq = done || error;
`endif

    ram_dma_cfg_regs #(.AW(AW)) u_cfg (
        .clock          (clock),
        .reset          (reset),
        .valid          (cfgValid),
        .write_enable   (cfgWriteEnable),
        .reg_sel        (cfgRegSel),
        .data_in        (cfgDataIn),
        .data_out       (cfgDataOut),
        .ack            (cfgDone),
        .lock           (state != S_IDLE),
        .busy           (busy),
        .error          (error),
        .done           (done),
        .bus_start_addr (bus_start_addr),
        .mem_start_addr (mem_start_addr),
        .block_size     (block_size),
        .burst_size     (burst_size),
        .start_bus2mem  (start_bus2mem),
        .start_mem2bus  (start_mem2bus),
        .status_clear   (status_clear)
    );

    // Next-state and bus/memory strobes; a bus error from any active state wins.
    always_comb begin
        state_next      = state;
        busRequest      = 1'b0;
        busStart        = 1'b0;
        memWriteEnable  = 1'b0;
        memDataOut      = '0;
        busDataValidOut = 1'b0;
        busDataOut      = '0;
        busEndOut       = 1'b0;
        case (state)
            S_IDLE:        state_next = (start_any && block_size != 16'd0) ? S_REQ : S_IDLE;
            S_REQ: begin
                busRequest = 1'b1;
                state_next = busGrant ? S_START : S_REQ;
            end
            S_START: begin
                busRequest = 1'b1;
                busStart   = 1'b1;
                state_next = dir ? S_RD_BEAT : S_WR_PREFETCH;
            end
            S_RD_BEAT: begin
                busRequest     = 1'b1;
                memWriteEnable = busDataValidIn;
                memDataOut     = busDataValidIn ? busDataIn : '0;
                state_next     = (busDataValidIn && last) ? S_NEXT : S_RD_BEAT;
            end
            S_WR_PREFETCH: begin
                busRequest = 1'b1;
                state_next = S_WR_BEAT;
            end
            S_WR_BEAT: begin
                busRequest      = 1'b1;
                busDataValidOut = 1'b1;
                busDataOut      = fresh ? memDataIn : wdata_hold;
                state_next      = (!busBusyIn && last) ? S_NEXT : S_WR_BEAT;
            end
            S_NEXT: begin
                busEndOut  = !dir;
                state_next = (rem_after == 16'd0) ? S_DONE : S_REQ;
            end
            default:       state_next = S_IDLE;
        endcase
        if (state != S_IDLE && busErrorIn) state_next = S_ERR;
    end

    // State register, transfer counters and status flags; fresh marks a word just arriving from the SSRAM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            error      <= 1'b0;
            done       <= 1'b0;
            dir        <= 1'b0;
            fresh      <= 1'b0;
            rem        <= '0;
            bus_addr   <= '0;
            mem_addr   <= '0;
            burst_len  <= '0;
            beat_cnt   <= '0;
            wdata_hold <= '0;
        end else begin
            state <= state_next;
            fresh <= 1'b0;
            if (status_clear) begin
                done  <= 1'b0;
                error <= 1'b0;
            end
            case (state)
                S_IDLE: if (start_any) begin
                    dir      <= start_bus2mem;
                    rem      <= block_size;
                    bus_addr <= bus_start_addr;
                    mem_addr <= mem_start_addr;
                    error    <= 1'b0;
                    busy     <= block_size != 16'd0;
                    done     <= block_size == 16'd0;
                end
                S_REQ: if (busGrant) begin
                    burst_len <= 8'(beats_now - 16'd1);
                    beat_cnt  <= 8'(beats_now - 16'd1);
                end
                S_RD_BEAT: if (busDataValidIn) begin
                    mem_addr <= mem_addr + 1'b1;
                    beat_cnt <= beat_cnt - 8'd1;
                end
                S_WR_PREFETCH: begin
                    mem_addr <= mem_addr + 1'b1;
                    fresh    <= 1'b1;
                end
                S_WR_BEAT: begin
                    wdata_hold <= busDataOut;
                    if (!busBusyIn) begin
                        mem_addr <= mem_addr + 1'b1;
                        beat_cnt <= beat_cnt - 8'd1;
                        fresh    <= 1'b1;
                    end
                end
                S_NEXT: begin
                    rem      <= rem_after;
                    bus_addr <= bus_addr + {14'd0, beats_done, 2'b00};
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
            if (state != S_IDLE && busErrorIn) begin
                busy  <= 1'b0;
                error <= 1'b1;
                done  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_dma_controller.sv
// tb_ram_dma_controller: directed bench for ram_dma_controller with an SSRAM port-B model; set RAM_DMA_IRQ_EN to also check irq.
module tb_ram_dma_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfgValid = 1'b0, cfgWriteEnable = 1'b0;
    logic [2:0]  cfgRegSel = 3'd0;
    logic [31:0] cfgDataIn = 32'd0;
    logic [31:0] cfgDataOut;
    logic        cfgDone;
    logic        busRequest, busStart, busReadNotWrite, busDataValidOut, busEndOut;
    logic        busGrant = 1'b0, busDataValidIn = 1'b0, busBusyIn = 1'b0, busErrorIn = 1'b0;
    logic [31:0] busAddress, busDataOut;
    logic [31:0] busDataIn = 32'd0;
    logic [7:0]  busBurstLen;
    logic [8:0]  memAddress;
    logic        memWriteEnable;
    logic [31:0] memDataOut, memDataIn;
`ifdef RAM_DMA_IRQ_EN
    logic        irq;
`endif

    logic [31:0] mem [512];
    logic [31:0] mem_q;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (memWriteEnable) mem[memAddress] <= memDataOut;
        mem_q <= mem[memAddress];
    end
    assign memDataIn = mem_q;

    ram_dma_controller #(.nrOfEntries(512), .bitwidth(32)) dut (
        .clock(clock), .reset(reset),
        .cfgValid(cfgValid), .cfgWriteEnable(cfgWriteEnable), .cfgRegSel(cfgRegSel),
        .cfgDataIn(cfgDataIn), .cfgDataOut(cfgDataOut), .cfgDone(cfgDone),
        .busRequest(busRequest), .busGrant(busGrant), .busStart(busStart),
        .busAddress(busAddress), .busBurstLen(busBurstLen), .busReadNotWrite(busReadNotWrite),
        .busDataIn(busDataIn), .busDataValidIn(busDataValidIn),
        .busDataOut(busDataOut), .busDataValidOut(busDataValidOut),
        .busBusyIn(busBusyIn), .busErrorIn(busErrorIn), .busEndOut(busEndOut),
        .memAddress(memAddress), .memWriteEnable(memWriteEnable),
        .memDataOut(memDataOut), .memDataIn(memDataIn)
`ifdef RAM_DMA_IRQ_EN
        , .irq(irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [31:0] data);
        cfgValid = 1'b1; cfgWriteEnable = 1'b1; cfgRegSel = sel; cfgDataIn = data;
        tick;
        cfgValid = 1'b0; cfgWriteEnable = 1'b0;
        check("cfg_ack", 32'(cfgDone), 32'd1);
    endtask

    task automatic cfg_read(input logic [2:0] sel, output logic [31:0] data);
        cfgValid = 1'b1; cfgWriteEnable = 1'b0; cfgRegSel = sel;
        tick;
        cfgValid = 1'b0;
        data = cfgDataOut;
    endtask

    task automatic grant_burst(input logic [31:0] exp_addr, input logic [7:0] exp_len, input logic exp_rnw);
        for (int i = 0; i < 20 && !busRequest; i++) tick;
        check("bus_request", 32'(busRequest), 32'd1);
        busGrant = 1'b1;
        tick;
        for (int i = 0; i < 20 && !busStart; i++) tick;
        busGrant = 1'b0;
        check("bus_start", 32'(busStart), 32'd1);
        check("burst_addr", busAddress, exp_addr);
        check("burst_len", 32'(busBurstLen), 32'(exp_len));
        check("burst_dir", 32'(busReadNotWrite), 32'(exp_rnw));
        tick;
    endtask

    task automatic read_burst(input logic [31:0] exp_addr, input logic [7:0] exp_len, input logic [31:0] first);
        grant_burst(exp_addr, exp_len, 1'b1);
        for (int i = 0; i <= int'(exp_len); i++) begin
            busDataValidIn = 1'b1;
            busDataIn = first + 32'(i);
            tick;
        end
        busDataValidIn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        logic [31:0] got [4];
        int k, ends, seen;
        bit stalled;

        repeat (3) tick;
        check("reset_ctl", 32'({busRequest, busStart, busReadNotWrite, memWriteEnable, busDataValidOut, busEndOut, cfgDone}), 32'd0);
        check("reset_data", busAddress | busDataOut | memDataOut | cfgDataOut | 32'(memAddress) | 32'(busBurstLen), 32'd0);
        reset = 1'b1;
        tick;
        cfg_read(3'd5, rd);
        check("reset_status", rd, 32'd0);

        // bus to memory, two bursts, low address bits dropped
        cfg_write(3'd0, 32'h0000_1003);
        cfg_write(3'd1, 32'd10);
        cfg_write(3'd2, 32'd5);
        cfg_write(3'd3, 32'd3);
        cfg_write(3'd4, 32'd1);
        read_burst(32'h1000, 8'd3, 32'hA0);
        read_burst(32'h1010, 8'd0, 32'hA4);
        repeat (2) tick;
        cfg_read(3'd5, rd);
        check("b2m_status", rd, 32'b100);
        for (int i = 0; i < 5; i++) check("b2m_mem", mem[10 + i], 32'hA0 + 32'(i));
`ifdef RAM_DMA_IRQ_EN
        check("irq_done", 32'(irq), 32'd1);
        cfg_write(3'd5, 32'd0);
        check("irq_clear", 32'(irq), 32'd0);
`endif

        // preload SSRAM 0..3 with 1..4
        cfg_write(3'd0, 32'h2000);
        cfg_write(3'd1, 32'd0);
        cfg_write(3'd2, 32'd4);
        cfg_write(3'd3, 32'd7);
        cfg_write(3'd4, 32'd1);
        read_burst(32'h2000, 8'd3, 32'd1);
        repeat (2) tick;

        // memory to bus, slave stalls once on beats 2 and 3
        cfg_write(3'd0, 32'h3000);
        cfg_write(3'd4, 32'd2);
        grant_burst(32'h3000, 8'd3, 1'b0);
        k = 0; ends = 0; stalled = 1'b0;
        for (int c = 0; c < 14; c++) begin
            busBusyIn = (k == 1 || k == 2) && !stalled;
            #1;
            if (busEndOut) ends++;
            if (busDataValidOut) begin
                if (busBusyIn) stalled = 1'b1;
                else begin
                    if (k < 4) got[k[1:0]] = busDataOut;
                    k++;
                    stalled = 1'b0;
                end
            end
            tick;
        end
        busBusyIn = 1'b0;
        check("m2b_beats", 32'(k), 32'd4);
        for (int i = 0; i < 4; i++) check("m2b_data", got[i], 32'(i + 1));
        check("m2b_end_pulses", 32'(ends), 32'd1);
        cfg_read(3'd5, rd);
        check("m2b_status", rd, 32'b100);

        // SSRAM address wraps past the top entry
        cfg_write(3'd0, 32'h4000);
        cfg_write(3'd1, 32'd510);
        cfg_write(3'd4, 32'd1);
        read_burst(32'h4000, 8'd3, 32'hC0);
        repeat (2) tick;
        check("wrap_510", mem[510], 32'hC0);
        check("wrap_511", mem[511], 32'hC1);
        check("wrap_0", mem[0], 32'hC2);
        check("wrap_1", mem[1], 32'hC3);

        // zero-length block completes without touching the bus
        cfg_write(3'd2, 32'd0);
        cfg_write(3'd4, 32'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (busRequest) seen++;
            tick;
        end
        check("zero_no_request", 32'(seen), 32'd0);
        cfg_read(3'd5, rd);
        check("zero_status", rd, 32'b100);

        // register writes are locked while busy but still acknowledged
        cfg_write(3'd0, 32'h5000);
        cfg_write(3'd1, 32'd20);
        cfg_write(3'd2, 32'd2);
        cfg_write(3'd4, 32'd1);
        cfg_read(3'd5, rd);
        check("busy_status", rd, 32'b001);
        cfg_write(3'd0, 32'h9000);
        read_burst(32'h5000, 8'd1, 32'hE0);
        repeat (2) tick;
        cfg_read(3'd0, rd);
        check("locked_reg0", rd, 32'h5000);
        cfg_read(3'd6, rd);
        check("reg6_zero", rd, 32'd0);

        // bus error on the second beat of a four-beat read
        cfg_write(3'd1, 32'd100);
        cfg_write(3'd2, 32'd4);
        cfg_write(3'd3, 32'd3);
        cfg_write(3'd4, 32'd1);
        grant_burst(32'h5000, 8'd3, 1'b1);
        busDataValidIn = 1'b1; busDataIn = 32'h11;
        tick;
        busDataIn = 32'h22; busErrorIn = 1'b1;
        tick;
        busDataValidIn = 1'b0; busErrorIn = 1'b0;
        check("err_request", 32'(busRequest), 32'd0);
`ifdef RAM_DMA_IRQ_EN
        check("irq_error", 32'(irq), 32'd1);
`endif
        cfg_read(3'd5, rd);
        check("err_status", rd, 32'b010);
        cfg_write(3'd5, 32'hFF);
`ifdef RAM_DMA_IRQ_EN
        check("irq_err_clear", 32'(irq), 32'd0);
`endif
        cfg_read(3'd5, rd);
        check("err_cleared", rd, 32'd0);

        // reset in the middle of a burst
        cfg_write(3'd0, 32'h6000);
        cfg_write(3'd1, 32'd40);
        cfg_write(3'd4, 32'd1);
        grant_burst(32'h6000, 8'd3, 1'b1);
        busDataValidIn = 1'b1; busDataIn = 32'h33;
        tick;
        reset = 1'b0;
        tick;
        check("midrst_ctl", 32'({busRequest, busStart, busReadNotWrite, memWriteEnable, busDataValidOut, busEndOut, cfgDone}), 32'd0);
        check("midrst_data", busAddress | busDataOut | memDataOut | cfgDataOut | 32'(memAddress) | 32'(busBurstLen), 32'd0);
        reset = 1'b1; busDataValidIn = 1'b0;
        tick;
        cfg_read(3'd5, rd);
        check("midrst_status", rd, 32'd0);
        cfg_read(3'd0, rd);
        check("midrst_reg0", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
